// File: rtl/alu_core.sv
// Registered 8-bit two-operand ALU with 16-bit result and compare flags.
// Optional feature macro ALU_DIV_EN: sel 7 becomes DIV instead of SHR.
module alu_core (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [7:0]  d0_in,
    input  logic [7:0]  d1_in,
    input  logic [2:0]  sel_in,
    output logic [15:0] res_out,
    output logic        gt_out,
    output logic        eq_out,
    output logic        valid_out
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_EXT = 3'd7;

    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] res_nxt;

    assign a16 = {8'h00, d0_in};
    assign b16 = {8'h00, d1_in};

    always_comb begin
        res_nxt = '0;
        unique case (sel_in)
            OP_ADD: res_nxt = a16 + b16;
            OP_SUB: res_nxt = a16 - b16;
            OP_MUL: res_nxt = a16 * b16;
            OP_AND: res_nxt = a16 & b16;
            OP_OR:  res_nxt = a16 | b16;
            OP_XOR: res_nxt = a16 ^ b16;
            OP_SHL: res_nxt = a16 << d1_in[3:0];
            OP_EXT: begin
`ifdef ALU_DIV_EN
                // Divide by zero saturates the whole result to all ones.
                if (d1_in == 8'h00)
                    res_nxt = 16'hFFFF;
                else
                    res_nxt = {d0_in % d1_in, d0_in / d1_in};
`else
                res_nxt = {8'h00, d0_in >> d1_in[2:0]};
`endif
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            res_out   <= '0;
            gt_out    <= 1'b0;
            eq_out    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                res_out <= res_nxt;
                gt_out  <= (d0_in > d1_in);
                eq_out  <= (d0_in == d1_in);
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard testbench for alu_core: expectations queued at issue,
// compared when valid_out is seen.
module tb_alu_core;

    logic        clk_in;
    logic        rst_in;
    logic        valid_in;
    logic [7:0]  d0_in;
    logic [7:0]  d1_in;
    logic [2:0]  sel_in;
    logic [15:0] res_out;
    logic        gt_out;
    logic        eq_out;
    logic        valid_out;

    typedef struct packed {
        logic [15:0] res;
        logic        gt;
        logic        eq;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    alu_core dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .d0_in     (d0_in),
        .d1_in     (d1_in),
        .sel_in    (sel_in),
        .res_out   (res_out),
        .gt_out    (gt_out),
        .eq_out    (eq_out),
        .valid_out (valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic exp_t model(int a, int b, int s);
        exp_t e;
        int r;
        case (s)
            0: r = a + b;
            1: r = (a - b + 65536) % 65536;
            2: r = a * b;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (a * (1 << (b % 16))) % 65536;
`ifdef ALU_DIV_EN
            default: r = (b == 0) ? 65535 : (a % b) * 256 + a / b;
`else
            default: r = a / (1 << (b % 8));
`endif
        endcase
        e.res = r[15:0];
        e.gt  = (a > b);
        e.eq  = (a == b);
        return e;
    endfunction

    // Outputs are sampled on the falling edge, away from the capture edge.
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: res=%0d gt=%0b eq=%0b, no op pending",
                         res_out, gt_out, eq_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({res_out, gt_out, eq_out} !== {e.res, e.gt, e.eq}) begin
                    bad++;
                    $display("FAIL result: got res=%0d gt=%0b eq=%0b, want res=%0d gt=%0b eq=%0b",
                             res_out, gt_out, eq_out, e.res, e.gt, e.eq);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input exp_t e);
        @(negedge clk_in);
        valid_in = 1'b1;
        d0_in = a;
        d1_in = b;
        sel_in = s;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        valid_in = 1'b0;
        d0_in = '0;
        d1_in = '0;
        sel_in = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        total++;
        if ({res_out, gt_out, eq_out, valid_out} !== 19'h0) begin
            bad++;
            $display("FAIL reset_state: got res=%0d gt=%0b eq=%0b vo=%0b, want all 0",
                     res_out, gt_out, eq_out, valid_out);
        end
        @(negedge clk_in);
        total++;
        if (valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: valid_out=%0b want 0", valid_out);
        end
    endtask

    task automatic test_sweep;
        int want[7] = '{110, 90, 1000, 0, 110, 110, 36864};
        exp_t e;
        for (int s = 0; s < 7; s++) begin
            e.res = want[s][15:0];
            e.gt = 1'b1;
            e.eq = 1'b0;
            issue(8'd100, 8'd10, s[2:0], e);
        end
        idle(1);
    endtask

    task automatic test_sel7;
        exp_t e;
`ifdef ALU_DIV_EN
        e = '{res: 16'h000A, gt: 1'b1, eq: 1'b0};
        issue(8'd100, 8'd10, 3'd7, e);
        e = '{res: 16'hFFFF, gt: 1'b1, eq: 1'b0};
        issue(8'd100, 8'd0, 3'd7, e);
`else
        e = '{res: 16'd25, gt: 1'b1, eq: 1'b0};
        issue(8'd100, 8'd10, 3'd7, e);
`endif
        idle(1);
    endtask

    task automatic test_boundary;
        issue(8'd10, 8'd100, 3'd1, '{res: 16'hFFA6, gt: 1'b0, eq: 1'b0});
        issue(8'd255, 8'd255, 3'd0, '{res: 16'd510, gt: 1'b0, eq: 1'b1});
        issue(8'd255, 8'd255, 3'd2, '{res: 16'd65025, gt: 1'b0, eq: 1'b1});
        issue(8'd0, 8'd0, 3'd5, '{res: 16'd0, gt: 1'b0, eq: 1'b1});
        idle(1);
    endtask

    task automatic test_hold;
        issue(8'd200, 8'd50, 3'd0, '{res: 16'd250, gt: 1'b1, eq: 1'b0});
        @(negedge clk_in);
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d0_in = 8'($urandom);
            d1_in = 8'($urandom);
            sel_in = 3'($urandom);
            @(negedge clk_in);
            total++;
            if ({valid_out, res_out, gt_out, eq_out} !== {1'b0, 16'd250, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL hold_%0d: got vo=%0b res=%0d gt=%0b eq=%0b, want vo=0 res=250 gt=1 eq=0",
                         i, valid_out, res_out, gt_out, eq_out);
            end
        end
    endtask

    task automatic test_reset_midstream;
        issue(8'd7, 8'd3, 3'd2, '{res: 16'd21, gt: 1'b1, eq: 1'b0});
        @(negedge clk_in);
        valid_in = 1'b1;
        rst_in = 1'b1;
        d0_in = 8'd99;
        d1_in = 8'd1;
        sel_in = 3'd0;
        @(negedge clk_in);
        rst_in = 1'b0;
        valid_in = 1'b0;
        total++;
        if ({valid_out, res_out, gt_out, eq_out} !== 19'h0) begin
            bad++;
            $display("FAIL reset_mid: got vo=%0b res=%0d gt=%0b eq=%0b, want all 0",
                     valid_out, res_out, gt_out, eq_out);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [2:0] s;
            a = 8'($urandom);
            b = (i % 6 == 0) ? a : 8'($urandom);
            s = 3'($urandom_range(0, 7));
            issue(a, b, s, model(int'(a), int'(b), int'(s)));
        end
        idle(1);
    endtask

    task automatic test_drain;
        int waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(negedge clk_in);
            waited++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results missing, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_sel7;
        test_boundary;
        test_hold;
        test_reset_midstream;
        test_back_to_back;
        idle(2);
        test_drain;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
